// File: rtl/rx_sample_framer.sv
// rx_sample_framer: frames strobed DSP I/Q samples into fixed-length packets,
// buffers them in a FWFT FIFO and drives a 36-bit src/dst-ready stream.
// Overrun stops the DSP and closes the open packet with an error terminator.
module rx_sample_framer #(
  parameter int BASE        = 176,
  parameter int FIFO_AWIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] sample,
  input  logic        strobe,
  output logic        run,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic        overrun,
  output logic [31:0] debug
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam logic [7:0] ADDR_SPP = 8'(BASE);
  localparam logic [7:0] ADDR_CMD = 8'(BASE + 1);
  localparam logic [FIFO_AWIDTH:0] FULL_CNT = {1'b1, {FIFO_AWIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_run;
  logic                   r_overrun;
  logic                   r_err;
  logic [15:0]            r_pkt_cnt;
  logic [15:0]            r_len;
  logic [15:0]            r_spp;
  logic [35:0]            r_mem [DEPTH];
  logic [FIFO_AWIDTH-1:0] r_wr_ptr;
  logic [FIFO_AWIDTH-1:0] r_rd_ptr;
  logic [FIFO_AWIDTH:0]   r_count;
  logic [35:0]            r_data;
  logic                   r_src_rdy;

  logic                   w_wr_spp;
  logic                   w_cmd_start;
  logic                   w_cmd_stop;
  logic                   w_full;
  logic [15:0]            w_spp_eff;
  logic [15:0]            w_len_cur;
  logic                   w_sof;
  logic                   w_eof;
  logic                   w_push;
  logic [35:0]            w_din;
  logic                   w_pop;
  logic [FIFO_AWIDTH:0]   w_count_next;
  logic [FIFO_AWIDTH:0]   w_left;
  logic [FIFO_AWIDTH-1:0] w_rd_next;
  logic [4:0]             w_count5;
  logic                   w_unused;

  assign w_wr_spp    = set_stb && (set_addr == ADDR_SPP);
  assign w_cmd_start = set_stb && (set_addr == ADDR_CMD) && set_data[0];
  assign w_cmd_stop  = set_stb && (set_addr == ADDR_CMD) && !set_data[0];
  assign w_unused    = &{1'b0, set_data[31:16]};

  // Full comes from registered occupancy only, so a same-cycle pop cannot mask overrun.
  assign w_full    = (r_count == FULL_CNT);
  assign w_spp_eff = (r_spp == 16'd0) ? 16'd1 : r_spp;
  // At sof the freshly latched length applies; mid-packet the held length does.
  assign w_len_cur = (r_pkt_cnt == 16'd0) ? w_spp_eff : r_len;
  assign w_sof     = (r_pkt_cnt == 16'd0);
  assign w_eof     = (r_pkt_cnt == (w_len_cur - 16'd1));

  // Select what (if anything) is written into the FIFO this cycle.
  always_comb begin
    w_push = 1'b0;
    w_din  = 36'd0;
    case (r_state)
      S_RUN: begin
        if (strobe && !w_full) begin
          w_push = 1'b1;
          w_din  = {1'b0, 1'b0, w_eof, w_sof, sample};
        end else begin
          w_push = 1'b0;
        end
      end
      S_CLOSE: begin
        if ((r_err || (r_pkt_cnt != 16'd0)) && !w_full) begin
          w_push = 1'b1;
          w_din  = {1'b0, r_err, 1'b1, (r_pkt_cnt == 16'd0), 32'd0};
        end else begin
          w_push = 1'b0;
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  // The word on data_o is the FIFO head; a transfer pops it.
  assign w_pop        = r_src_rdy && dst_rdy_i;
  assign w_count_next = r_count + {{FIFO_AWIDTH{1'b0}}, w_push} - {{FIFO_AWIDTH{1'b0}}, w_pop};
  assign w_left       = r_count - {{FIFO_AWIDTH{1'b0}}, w_pop};
  assign w_rd_next    = r_rd_ptr + {{(FIFO_AWIDTH-1){1'b0}}, w_pop};

  // Samples-per-packet register; takes effect at the next sof.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spp <= 16'd1;
    end else if (w_wr_spp) begin
      r_spp <= set_data[15:0];
    end
  end

  // Framing state machine: run control, packet counter, overrun and terminator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b0;
      r_overrun <= 1'b0;
      r_err     <= 1'b0;
      r_pkt_cnt <= 16'd0;
      r_len     <= 16'd1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_start) begin
            r_overrun <= 1'b0;
            r_pkt_cnt <= 16'd0;
            r_run     <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (strobe && w_full) begin
            r_overrun <= 1'b1;
            r_err     <= 1'b1;
            r_run     <= 1'b0;
            r_state   <= S_CLOSE;
          end else begin
            if (strobe) begin
              if (w_sof) begin
                r_len <= w_spp_eff;
              end
              r_pkt_cnt <= w_eof ? 16'd0 : (r_pkt_cnt + 16'd1);
            end
            if (w_cmd_stop) begin
              r_err   <= 1'b0;
              r_run   <= 1'b0;
              r_state <= S_CLOSE;
            end
          end
        end
        S_CLOSE: begin
          if (!r_err && (r_pkt_cnt == 16'd0)) begin
            r_state <= S_IDLE;
          end else if (!w_full) begin
            r_pkt_cnt <= 16'd0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_run   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_din;
    end
  end

  // FIFO pointers, occupancy and the registered first-word-fall-through head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_src_rdy <= 1'b0;
      r_data    <= 36'd0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + {{(FIFO_AWIDTH-1){1'b0}}, w_push};
      r_rd_ptr  <= w_rd_next;
      r_count   <= w_count_next;
      r_src_rdy <= (w_count_next != '0);
      if (w_count_next == '0) begin
        r_data <= r_data;
      end else if (w_left == '0) begin
        r_data <= w_din;
      end else begin
        r_data <= r_mem[w_rd_next];
      end
    end
  end

  assign w_count5  = 5'(r_count);
  assign run       = r_run;
  assign overrun   = r_overrun;
  assign data_o    = r_data;
  assign src_rdy_o = r_src_rdy;
  assign debug     = {r_state, r_overrun, r_run, w_count5, 7'd0, r_pkt_cnt};

endmodule
